// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode decode, byte geometry, default transmit byte
// and the responder FSM state type.
package spi_pkg;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = $clog2(BYTE_W);
    localparam logic [CNT_W-1:0]  BIT_MSB        = CNT_W'(BYTE_W - 1);
    localparam logic [BYTE_W-1:0] SPI_DEFAULT_TX = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_XFER = 2'd2
    } spi_state_t;

    // Clock idle level for the given SPI mode.
    function automatic logic cpol(input int mode);
        return (mode == 2) || (mode == 3);
    endfunction

    // Clock phase for the given SPI mode: 1 = sample on the trailing edge.
    function automatic logic cpha(input int mode);
        return (mode == 1) || (mode == 3);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser with one-cycle rise/fall pulses on the synced value.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_D,
    output logic o_Q,
    output logic o_Rise,
    output logic o_Fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Shift the asynchronous input through the flop chain and keep the
    // previous synced value for edge detection.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_D};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_Q    = r_sync[STAGES-1];
    assign o_Rise = r_sync[STAGES-1] & ~r_prev;
    assign o_Fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversamples SCLK/CS_n/MOSI in the system clock domain,
// deserialises MOSI into bytes and serialises a user byte onto MISO, MSb first.
// Optional macro SPI_SLAVE_MISO_TRISTATE_EN: when defined, o_SPI_MISO_OE
// follows chip-select so MISO can share a tristated line; otherwise it is 1.
//
// state   | meaning
// IDLE    | CS_n high, SCLK edges ignored
// LOAD    | one cycle after CS_n falls, shift register loaded
// XFER    | bits moving on SCLK edges, bursts allowed while CS_n low
module spi_slave
    import spi_pkg::*;
#(
    parameter int                SPI_MODE    = 0,
    parameter int                SYNC_STAGES = 2,
    parameter logic [BYTE_W-1:0] DEFAULT_TX  = SPI_DEFAULT_TX
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [BYTE_W-1:0] i_TX_Byte,
    input  logic              i_TX_DV,
    output logic              o_TX_Ready,
    output logic              o_RX_DV,
    output logic [BYTE_W-1:0] o_RX_Byte,
    output logic              o_CS_Active,
    input  logic              i_SPI_Clk,
    input  logic              i_SPI_CS_n,
    input  logic              i_SPI_MOSI,
    output logic              o_SPI_MISO,
    output logic              o_SPI_MISO_OE
);

    localparam logic CPOL = cpol(SPI_MODE);
    localparam logic CPHA = cpha(SPI_MODE);

    logic w_sclk, w_sclk_rise, w_sclk_fall;
    logic w_cs_n, w_cs_rise, w_cs_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_unused_sync;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .i_D   (i_SPI_Clk),
        .o_Q   (w_sclk),
        .o_Rise(w_sclk_rise),
        .o_Fall(w_sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .i_D   (i_SPI_CS_n),
        .o_Q   (w_cs_n),
        .o_Rise(w_cs_rise),
        .o_Fall(w_cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .i_D   (i_SPI_MOSI),
        .o_Q   (w_mosi),
        .o_Rise(w_mosi_rise),
        .o_Fall(w_mosi_fall)
    );

    // Synchroniser outputs this block has no use for.
    assign w_unused_sync = ^{w_sclk, w_cs_rise, w_mosi_rise, w_mosi_fall};

    logic w_lead_edge, w_trail_edge, w_sample_edge, w_shift_edge;

    assign w_lead_edge   = CPOL ? w_sclk_fall : w_sclk_rise;
    assign w_trail_edge  = CPOL ? w_sclk_rise : w_sclk_fall;
    assign w_sample_edge = CPHA ? w_trail_edge : w_lead_edge;
    assign w_shift_edge  = CPHA ? w_lead_edge  : w_trail_edge;

    spi_state_t r_state, w_state_nx;
    logic       w_load, w_abort, w_rx_sample, w_tx_shift, w_tx_last, w_reload;

    logic [BYTE_W-1:0] r_tx_hold, r_tx_shift, r_rx_shift, r_rx_byte, w_reload_byte;
    logic              r_hold_full, r_miso, r_done_d, r_rx_dv;
    logic [CNT_W-1:0]  r_tx_bit, r_rx_bit;

    // State register.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nx;
    end

    // Next state and per-cycle datapath strobes; CS_n high always aborts.
    always_comb begin
        w_state_nx  = r_state;
        w_load      = 1'b0;
        w_abort     = 1'b0;
        w_rx_sample = 1'b0;
        w_tx_shift  = 1'b0;
        case (r_state)
            ST_IDLE: if (w_cs_fall) w_state_nx = ST_LOAD;
            ST_LOAD: begin
                if (w_cs_n) begin
                    w_abort    = 1'b1;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_load     = 1'b1;
                    w_state_nx = ST_XFER;
                end
            end
            ST_XFER: begin
                if (w_cs_n) begin
                    w_abort    = 1'b1;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_rx_sample = w_sample_edge;
                    w_tx_shift  = w_shift_edge;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // CPHA=0 drives the MSb at reload time, so its counter sits at 7 only
    // once all eight bits are out; CPHA=1 drives bit 0 on the 8th shift edge.
    assign w_tx_last     = w_tx_shift && (CPHA ? (r_tx_bit == '0) : (r_tx_bit == BIT_MSB));
    assign w_reload      = w_load | w_tx_last;
    assign w_reload_byte = i_TX_DV     ? i_TX_Byte :
                           r_hold_full ? r_tx_hold : DEFAULT_TX;

    // Holding register: a strobe landing on a reload bypasses it.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_tx_hold   <= '0;
            r_hold_full <= 1'b0;
        end else if (w_reload) begin
            r_hold_full <= 1'b0;
        end else if (i_TX_DV) begin
            r_tx_hold   <= i_TX_Byte;
            r_hold_full <= 1'b1;
        end
    end

    // Transmit shifter and MISO driver.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_tx_shift <= DEFAULT_TX;
            r_tx_bit   <= BIT_MSB;
            r_miso     <= DEFAULT_TX[BYTE_W-1];
        end else if (w_abort) begin
            r_tx_bit <= BIT_MSB;
        end else begin
            if (w_reload) r_tx_shift <= w_reload_byte;
            if (CPHA == 1'b0) begin
                if (w_reload) begin
                    r_miso   <= w_reload_byte[BYTE_W-1];
                    r_tx_bit <= BIT_MSB - 1'b1;
                end else if (w_tx_shift) begin
                    r_miso   <= r_tx_shift[r_tx_bit];
                    r_tx_bit <= r_tx_bit - 1'b1;
                end
            end else begin
                if (w_tx_shift) begin
                    r_miso   <= r_tx_shift[r_tx_bit];
                    r_tx_bit <= r_tx_bit - 1'b1;
                end else if (w_load) begin
                    r_tx_bit <= BIT_MSB;
                end
            end
        end
    end

    // Receive shifter; a completed byte is published on the last sample edge.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_rx_shift <= '0;
            r_rx_bit   <= BIT_MSB;
            r_rx_byte  <= '0;
        end else if (w_abort) begin
            r_rx_bit <= BIT_MSB;
        end else if (w_rx_sample) begin
            r_rx_shift[r_rx_bit] <= w_mosi;
            r_rx_bit             <= r_rx_bit - 1'b1;
            if (r_rx_bit == '0) r_rx_byte <= {r_rx_shift[BYTE_W-1:1], w_mosi};
        end
    end

    // Byte-valid pulse lands the cycle after o_RX_Byte updates.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_done_d <= 1'b0;
            r_rx_dv  <= 1'b0;
        end else begin
            r_done_d <= w_rx_sample && (r_rx_bit == '0);
            r_rx_dv  <= r_done_d;
        end
    end

    assign o_TX_Ready  = ~r_hold_full;
    assign o_RX_DV     = r_rx_dv;
    assign o_RX_Byte   = r_rx_byte;
    assign o_CS_Active = ~w_cs_n;
    assign o_SPI_MISO  = r_miso;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign o_SPI_MISO_OE = ~w_cs_n;
`else
    assign o_SPI_MISO_OE = 1'b1;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one responder per SPI mode, each driven by a
// behavioural SPI master; expected bytes come from a holding-register model.
module tb_spi_slave;
    import spi_pkg::*;

    localparam int H = 8;   // SCLK half period in system clocks

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    localparam bit TRI = 1'b1;
`else
    localparam bit TRI = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_byte = 8'h00;
    logic [3:0] tx_dv = 4'h0;
    logic [3:0] sclk  = 4'b1100;
    logic [3:0] cs_n  = 4'hF;
    logic [3:0] mosi  = 4'h0;
    logic [3:0] tx_ready, rx_dv, cs_act, miso, miso_oe;
    logic [7:0] rx_byte [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave #(.SPI_MODE(g)) u_dut (
            .i_Clk        (clk),
            .i_Rst        (rst),
            .i_TX_Byte    (tx_byte),
            .i_TX_DV      (tx_dv[g]),
            .o_TX_Ready   (tx_ready[g]),
            .o_RX_DV      (rx_dv[g]),
            .o_RX_Byte    (rx_byte[g]),
            .o_CS_Active  (cs_act[g]),
            .i_SPI_Clk    (sclk[g]),
            .i_SPI_CS_n   (cs_n[g]),
            .i_SPI_MOSI   (mosi[g]),
            .o_SPI_MISO   (miso[g]),
            .o_SPI_MISO_OE(miso_oe[g])
        );
    end

    int         n_cmp = 0;
    int         n_fail = 0;
    int         dv_cnt [4] = '{default: 0};
    logic [7:0] last_rx [4];
    int         hold [4] = '{default: -1};   // pending user byte, -1 = none
    int         nxt [4] = '{default: 255};   // byte the responder will send next
    logic [7:0] got;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rx_dv[i]) begin
                dv_cnt[i]  = dv_cnt[i] + 1;
                last_rx[i] = rx_byte[i];
            end
        end
    end

    function automatic int take(input int m);
        int v;
        v = (hold[m] < 0) ? int'(SPI_DEFAULT_TX) : hold[m];
        hold[m] = -1;
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int m, input logic [7:0] b);
        tx_byte  = b;
        tx_dv[m] = 1'b1;
        tick(1);
        tx_dv[m] = 1'b0;
        hold[m]  = int'(b);
        check("tx_ready_clear", int'(tx_ready[m]), 0);
    endtask

    task automatic cs_start(input int m);
        cs_n[m] = 1'b0;
        nxt[m]  = take(m);
        tick(H);
        check("cs_active_on", int'(cs_act[m]), 1);
        check("tx_ready_after_load", int'(tx_ready[m]), 1);
        check("miso_oe_active", int'(miso_oe[m]), 1);
    endtask

    task automatic cs_end(input int m);
        tick(H);
        cs_n[m] = 1'b1;
        tick(H);
        check("cs_active_off", int'(cs_act[m]), 0);
        check("miso_oe_idle", int'(miso_oe[m]), TRI ? 0 : 1);
    endtask

    // Clock bits hi..lo of tx out on MOSI, capturing MISO into got.
    task automatic xbits(input int m, input logic [7:0] tx, input int hi, input int lo);
        logic pol, pha;
        pol = m[1];
        pha = m[0];
        for (int b = hi; b >= lo; b--) begin
            if (!pha) begin
                mosi[m] = tx[b];
                tick(H);
                got[b]  = miso[m];
                sclk[m] = ~pol;
                tick(H);
                sclk[m] = pol;
            end else begin
                tick(H);
                sclk[m] = ~pol;
                mosi[m] = tx[b];
                tick(H);
                got[b]  = miso[m];
                sclk[m] = pol;
            end
        end
    endtask

    // One full byte; ld >= 0 loads a user byte halfway through.
    task automatic full_byte(input int m, input logic [7:0] tx, input int ld);
        int exp_tx, d0;
        exp_tx = nxt[m];
        d0     = dv_cnt[m];
        got    = 8'h00;
        xbits(m, tx, 7, 4);
        if (ld >= 0) load(m, 8'(ld));
        xbits(m, tx, 3, 0);
        tick(H);
        nxt[m] = take(m);
        check("master_rx_byte", int'(got), exp_tx);
        check("rx_dv_pulses", dv_cnt[m], d0 + 1);
        check("rx_dv_byte", int'(last_rx[m]), int'(tx));
        check("rx_byte_out", int'(rx_byte[m]), int'(tx));
    endtask

    initial begin
        int d0, m, nb, ld;
        logic [7:0] d;

        tick(3);
        for (int i = 0; i < 4; i++) begin
            check("rst_tx_ready", int'(tx_ready[i]), 1);
            check("rst_rx_dv", int'(rx_dv[i]), 0);
            check("rst_rx_byte", int'(rx_byte[i]), 0);
            check("rst_cs_active", int'(cs_act[i]), 0);
            check("rst_miso", int'(miso[i]), 1);
            check("rst_miso_oe", int'(miso_oe[i]), TRI ? 0 : 1);
        end
        rst = 1'b0;
        tick(4);

        // Mode 0 basic exchange.
        load(0, 8'hA5);
        cs_start(0);
        full_byte(0, 8'h3C, -1);
        cs_end(0);

        // Modes 1..3.
        for (int k = 1; k < 4; k++) begin
            load(k, 8'hC3);
            cs_start(k);
            full_byte(k, 8'h5A, -1);
            cs_end(k);
        end

        // Bursts: every byte preloaded, then the third byte left to default.
        load(0, 8'h01);
        cs_start(0);
        full_byte(0, 8'h11, 8'h02);
        full_byte(0, 8'h22, 8'h03);
        full_byte(0, 8'h33, -1);
        cs_end(0);
        load(0, 8'h01);
        cs_start(0);
        full_byte(0, 8'h44, 8'h02);
        full_byte(0, 8'h55, -1);
        full_byte(0, 8'h66, -1);
        cs_end(0);

        // Abort after five SCLK cycles; a byte loaded meanwhile is retained.
        cs_start(0);
        d0 = dv_cnt[0];
        got = 8'h00;
        xbits(0, 8'hAB, 7, 3);
        load(0, 8'h77);
        tick(H);
        cs_n[0] = 1'b1;
        tick(2 * H);
        check("abort_no_rx_dv", dv_cnt[0], d0);
        check("abort_hold_kept", int'(tx_ready[0]), 0);
        cs_start(0);
        full_byte(0, 8'h96, -1);
        cs_end(0);

        // Reset mid-byte in mode 1.
        load(1, 8'h12);
        cs_start(1);
        xbits(1, 8'hE7, 7, 4);
        rst     = 1'b1;
        cs_n[1] = 1'b1;
        sclk[1] = 1'b0;
        tick(1);
        for (int i = 0; i < 4; i++) hold[i] = -1;
        check("midrst_tx_ready", int'(tx_ready[1]), 1);
        check("midrst_rx_dv", int'(rx_dv[1]), 0);
        check("midrst_rx_byte", int'(rx_byte[1]), 0);
        check("midrst_cs_active", int'(cs_act[1]), 0);
        check("midrst_miso", int'(miso[1]), 1);
        tick(2);
        rst = 1'b0;
        tick(4);
        load(1, 8'h3A);
        cs_start(1);
        full_byte(1, 8'h69, -1);
        cs_end(1);

        // Randomised transfers against the model.
        for (int it = 0; it < 12; it++) begin
            m  = int'($urandom_range(3, 0));
            nb = int'($urandom_range(3, 1));
            if ($urandom_range(1, 0) == 1) begin
                d = 8'($urandom_range(255, 0));
                load(m, d);
            end
            cs_start(m);
            for (int j = 0; j < nb; j++) begin
                d  = 8'($urandom_range(255, 0));
                ld = ($urandom_range(1, 0) == 1) ? int'($urandom_range(255, 0)) : -1;
                full_byte(m, d, ld);
            end
            cs_end(m);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
